alu_arbiter: RTL and testbench

//  Shares the single combinational ALU between NUM_REQ issue requesters (e.g. hardware threads).

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/types.sv | 8 +
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter_rr.sv | 47 ++++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 177 +++++++++++++++++
 6 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - flag types and constants for the ALU arbiter
// Ports: none (package)
package alu_arb_pkg;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic sn;
   } flags_t;

   localparam flags_t FLAGS_RST = '0;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

endpackage

// File: rtl/types.sv
// rtl/types.sv - shared datapath types used by the ALU and its arbiter
// Ports: none (package)
package types;

   typedef logic [31:0] instruction_t;
   typedef logic [63:0] long_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/ALU/response bundle between issue stage, ALU and writeback
// Ports: slave = arbiter view (takes requests, drives ALU and response), master = environment view
interface alu_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import types::*;
   import alu_arb_pkg::*;

   localparam int ID_W = $clog2(NUM_REQ);

   logic                             flush;
   logic         [NUM_REQ-1:0]       req_valid;
   logic         [NUM_REQ-1:0]       req_ready;
   instruction_t [NUM_REQ-1:0]       req_instr;
   logic         [NUM_REQ-1:0]       req_set_flags;
   instruction_t                     alu_instr;
   logic                             alu_carry;
   long_t                            alu_result;
   logic                             alu_z;
   logic                             alu_n;
   logic                             alu_c;
   logic                             alu_sn;
   logic                             rsp_valid;
   logic                             rsp_ready;
   logic         [ID_W-1:0]          rsp_id;
   long_t                            rsp_result;
   flags_t                           rsp_flags;
   flags_t       [NUM_REQ-1:0]       flags_q;

   modport slave (
      input  flush, req_valid, req_instr, req_set_flags,
      input  alu_result, alu_z, alu_n, alu_c, alu_sn, rsp_ready,
      output req_ready, alu_instr, alu_carry,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q
   );

   modport master (
      output flush, req_valid, req_instr, req_set_flags,
      output alu_result, alu_z, alu_n, alu_c, alu_sn, rsp_ready,
      input  req_ready, alu_instr, alu_carry,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q
   );

endinterface

// File: rtl/alu_arbiter_rr.sv
// rtl/alu_arbiter_rr.sv - round-robin arbiter rr_arbiter with its own rotating pointer
// Ports: clk, rst (async high), req[N] in, advance in, grant[N] one-hot out, grant_id out
module rr_arbiter #(
   parameter int N    = 2,
   parameter int ID_W = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            advance,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id
);

   logic [ID_W-1:0] ptr_q, ptr_d;

   // Scan from the pointer upward, wrapping; first requester found wins.
   always_comb begin
      int   idx;
      logic found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant[idx] = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + ID_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU among NUM_REQ requesters, registers result into a response slot
// Ports: clk, rst (async high), bus (alu_arbiter_if.slave); perf_grants[NUM_REQ] when ALU_ARB_PERF_EN
module alu_arbiter
   import types::*;
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef ALU_ARB_PERF_EN
   output logic [NUM_REQ-1:0][31:0] perf_grants,
`endif
   alu_arbiter_if.slave             bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               any_grant;
   logic               can_accept;
   logic               accept;
   flags_t             alu_flags;

   rsp_state_t               state_q, state_d;
   logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
   long_t                    rsp_result_q, rsp_result_d;
   flags_t                   rsp_flags_q, rsp_flags_d;
   flags_t [NUM_REQ-1:0]     flags_q, flags_d;

   rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
      .clk      (clk),
      .rst      (rst),
      .req      (bus.req_valid),
      .advance  (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign any_grant = |grant;
   // Reset gating keeps req_ready low while rst is held even though the slot reads empty.
   assign can_accept = !rst && !bus.flush && (state_q == RSP_EMPTY || bus.rsp_ready);
   assign accept     = any_grant && can_accept;
   assign alu_flags  = '{z: bus.alu_z, n: bus.alu_n, c: bus.alu_c, sn: bus.alu_sn};

   assign bus.req_ready  = grant & {NUM_REQ{can_accept}};
   assign bus.alu_instr  = any_grant ? bus.req_instr[grant_id] : '0;
   assign bus.alu_carry  = any_grant ? flags_q[grant_id].c : 1'b0;
   assign bus.rsp_valid  = (state_q == RSP_FULL);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.flags_q    = flags_q;

   always_comb begin
      state_d      = state_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      flags_d      = flags_q;
      if (accept) begin
         // Refill covers both the empty case and drain-plus-accept in one cycle.
         state_d      = RSP_FULL;
         rsp_id_d     = grant_id;
         rsp_result_d = bus.alu_result;
         rsp_flags_d  = alu_flags;
         if (bus.req_set_flags[grant_id]) begin
            flags_d[grant_id] = alu_flags;
         end
      end else if (bus.flush || (state_q == RSP_FULL && bus.rsp_ready)) begin
         state_d = RSP_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RSP_EMPTY;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= FLAGS_RST;
         flags_q      <= {NUM_REQ{FLAGS_RST}};
      end else begin
         state_q      <= state_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         flags_q      <= flags_d;
      end
   end

`ifdef ALU_ARB_PERF_EN
   logic [NUM_REQ-1:0][31:0] perf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && grant[i]) perf_q[i] <= perf_q[i] + 32'd1;
         end
      end
   end

   assign perf_grants = perf_q;
`else
   // No accept counters in this build.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter
module tb_alu_arbiter;
   import types::*;
   import alu_arb_pkg::*;

   localparam flags_t F_0 = 4'b0000;
   localparam flags_t F_C = 4'b0010;
   localparam flags_t F_Z = 4'b1000;

   typedef struct {
      logic [1:0]  rv;
      logic [1:0]  sf;
      logic        rr;
      logic        fl;
      logic [63:0] res;
      flags_t      f;
      logic [1:0]  e_rdy;
      logic        e_carry;
      logic        e_v;
      logic        e_id;
      logic [63:0] e_res;
      flags_t      e_flg;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   int   acc0 = 0;
   int   acc1 = 0;

   alu_arbiter_if #(.NUM_REQ(2)) bus ();

`ifdef ALU_ARB_PERF_EN
   logic [1:0][31:0] perf_grants;
`endif

   alu_arbiter #(.NUM_REQ(2)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef ALU_ARB_PERF_EN
      .perf_grants (perf_grants),
`endif
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] sf, input logic rr,
                               input logic fl, input logic [63:0] res, input flags_t f,
                               input logic [1:0] e_rdy, input logic e_carry, input logic e_v,
                               input logic e_id, input logic [63:0] e_res, input flags_t e_flg);
      vec_t v;
      v.rv = rv; v.sf = sf; v.rr = rr; v.fl = fl; v.res = res; v.f = f;
      v.e_rdy = e_rdy; v.e_carry = e_carry; v.e_v = e_v; v.e_id = e_id;
      v.e_res = e_res; v.e_flg = e_flg;
      return v;
   endfunction

   vec_t vecs [17];

   initial begin
      //             rv     sf     rr    fl    res      f    e_rdy  cy    v     id    e_res    e_flg
      vecs[0]  = mk(2'b01, 2'b00, 1'b1, 1'b0, 64'h05, F_0, 2'b01, 1'b0, 1'b1, 1'b0, 64'h05, F_0);
      vecs[1]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 64'h10, F_0, 2'b10, 1'b0, 1'b1, 1'b1, 64'h10, F_0);
      vecs[2]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 64'h20, F_0, 2'b01, 1'b0, 1'b1, 1'b0, 64'h20, F_0);
      vecs[3]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 64'h30, F_0, 2'b10, 1'b0, 1'b1, 1'b1, 64'h30, F_0);
      vecs[4]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 64'h40, F_0, 2'b01, 1'b0, 1'b1, 1'b0, 64'h40, F_0);
      vecs[5]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 64'h50, F_0, 2'b10, 1'b0, 1'b1, 1'b1, 64'h50, F_0);
      vecs[6]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 64'h60, F_0, 2'b00, 1'b0, 1'b1, 1'b1, 64'h50, F_0);
      vecs[7]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 64'h61, F_0, 2'b00, 1'b0, 1'b1, 1'b1, 64'h50, F_0);
      vecs[8]  = mk(2'b01, 2'b00, 1'b1, 1'b0, 64'h70, F_0, 2'b01, 1'b0, 1'b1, 1'b0, 64'h70, F_0);
      vecs[9]  = mk(2'b01, 2'b01, 1'b1, 1'b0, 64'h80, F_C, 2'b01, 1'b0, 1'b1, 1'b0, 64'h80, F_C);
      vecs[10] = mk(2'b11, 2'b11, 1'b1, 1'b0, 64'h90, F_0, 2'b10, 1'b0, 1'b1, 1'b1, 64'h90, F_0);
      vecs[11] = mk(2'b01, 2'b00, 1'b1, 1'b0, 64'hA0, F_0, 2'b01, 1'b1, 1'b1, 1'b0, 64'hA0, F_0);
      vecs[12] = mk(2'b01, 2'b00, 1'b1, 1'b0, 64'hA1, F_0, 2'b01, 1'b1, 1'b1, 1'b0, 64'hA1, F_0);
      vecs[13] = mk(2'b00, 2'b00, 1'b1, 1'b0, 64'h00, F_0, 2'b00, 1'b0, 1'b0, 1'b0, 64'h00, F_0);
      vecs[14] = mk(2'b10, 2'b00, 1'b1, 1'b0, 64'hB0, F_0, 2'b10, 1'b0, 1'b1, 1'b1, 64'hB0, F_0);
      vecs[15] = mk(2'b01, 2'b01, 1'b1, 1'b1, 64'hC0, F_Z, 2'b00, 1'b1, 1'b0, 1'b0, 64'h00, F_0);
      vecs[16] = mk(2'b11, 2'b00, 1'b1, 1'b0, 64'hD0, F_0, 2'b01, 1'b1, 1'b1, 1'b0, 64'hD0, F_0);

      bus.flush         = 1'b0;
      bus.req_valid     = 2'b00;
      bus.req_set_flags = 2'b00;
      bus.req_instr[0]  = 32'h0000_00A0;
      bus.req_instr[1]  = 32'h0000_00B1;
      bus.alu_result    = '0;
      bus.alu_z = 1'b0; bus.alu_n = 1'b0; bus.alu_c = 1'b0; bus.alu_sn = 1'b0;
      bus.rsp_ready     = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_id",     64'(bus.rsp_id), 64'd0);
      chk("rst_rsp_result", bus.rsp_result, 64'd0);
      chk("rst_rsp_flags",  64'(bus.rsp_flags), 64'd0);
      chk("rst_flags_q",    64'(bus.flags_q), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         bus.req_valid     = vecs[i].rv;
         bus.req_set_flags = vecs[i].sf;
         bus.rsp_ready     = vecs[i].rr;
         bus.flush         = vecs[i].fl;
         bus.alu_result    = vecs[i].res;
         {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_sn} = vecs[i].f;
         #1;
         chk($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_rdy));
         chk($sformatf("v%0d_alu_carry", i), 64'(bus.alu_carry), 64'(vecs[i].e_carry));
         if (vecs[i].e_rdy[0]) acc0++;
         if (vecs[i].e_rdy[1]) acc1++;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].e_v));
         if (vecs[i].e_v) begin
            chk($sformatf("v%0d_rsp_id", i), 64'(bus.rsp_id), 64'(vecs[i].e_id));
            chk($sformatf("v%0d_rsp_result", i), bus.rsp_result, vecs[i].e_res);
            chk($sformatf("v%0d_rsp_flags", i), 64'(bus.rsp_flags), 64'(vecs[i].e_flg));
         end
      end

      chk("flags_q0_after", 64'(bus.flags_q[0]), 64'(F_C));
      chk("flags_q1_after", 64'(bus.flags_q[1]), 64'(F_0));

      @(negedge clk);
      bus.flush     = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 2'b10;
      #1;
      chk("alu_instr_req1", 64'(bus.alu_instr), 64'h0000_00B1);
      chk("alu_carry_req1", 64'(bus.alu_carry), 64'd0);
      bus.req_valid = 2'b00;
      #1;
      chk("alu_instr_idle", 64'(bus.alu_instr), 64'd0);

`ifdef ALU_ARB_PERF_EN
      chk("perf_grants0", 64'(perf_grants[0]), 64'(acc0));
      chk("perf_grants1", 64'(perf_grants[1]), 64'(acc1));
`endif

      // Mid-operation reset with a held response and a pending request.
      bus.req_valid = 2'b01;
      #1;
      chk("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("midrst_flags_q",   64'(bus.flags_q), 64'd0);
      chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_hold_ready",  64'(bus.req_ready), 64'd0);
      chk("midrst_hold_result", bus.rsp_result, 64'd0);
      chk("midrst_hold_valid",  64'(bus.rsp_valid), 64'd0);
`ifdef ALU_ARB_PERF_EN
      chk("midrst_perf0", 64'(perf_grants[0]), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_grant0", 64'(bus.req_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
